// File: rtl/dual_request_queue.sv
// Two independent circular request FIFOs feeding an external round-robin arbiter.
// Optional sticky illegal-grant detection enabled by `define DUAL_REQUEST_QUEUE_ERR_CHECK_EN.
module dual_request_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       push_valid,
    output logic [1:0]       push_ready,
    input  logic [WIDTH-1:0] push_data0,
    input  logic [WIDTH-1:0] push_data1,
    output logic [1:0]       requests,
    input  logic [1:0]       grants,
    output logic             out_valid,
    output logic             out_src,
    output logic [WIDTH-1:0] out_data,
    output logic             err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wptr  [2];
    logic [AW-1:0]    rptr  [2];
    logic [CW-1:0]    count [2];
    logic [WIDTH-1:0] mem   [2][DEPTH];
    logic [WIDTH-1:0] wdata [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic       grant_ok;
    logic       gsel;

    assign wdata[0] = push_data0;
    assign wdata[1] = push_data1;

    // Status flags come only from registered counts, never from push_valid.
    assign push_ready = {count[1] != CW'(DEPTH), count[0] != CW'(DEPTH)};
    assign requests   = {count[1] != CW'(0), count[0] != CW'(0)};

    assign grant_ok = ((grants == 2'b01) && requests[0]) ||
                      ((grants == 2'b10) && requests[1]);
    assign gsel     = grants[1];
    assign pop      = grant_ok ? grants : 2'b00;
    assign push     = push_valid & push_ready;

    // Pointers and occupancy per queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + AW'(1);
                if (pop[i])  rptr[i] <= rptr[i] + AW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage is intentionally unreset; stale slots are unreachable via count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wptr[i]] <= wdata[i];
        end
    end

    // Output register: data/src hold when no legal grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= grant_ok;
            if (grant_ok) begin
                out_src  <= gsel;
                out_data <= mem[gsel][rptr[gsel]];
            end
        end
    end

`ifdef DUAL_REQUEST_QUEUE_ERR_CHECK_EN
    logic illegal;
    logic err_q;

    // 11, or a one-hot grant aimed at an empty queue.
    assign illegal = (grants == 2'b11) || ((grants[0] ^ grants[1]) && !grant_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         err_q <= 1'b0;
        else if (illegal) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_request_queue.sv
// Self-checking bench for dual_request_queue: queue-based reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_dual_request_queue;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       push_valid;
    logic [1:0]       push_ready;
    logic [WIDTH-1:0] push_data0;
    logic [WIDTH-1:0] push_data1;
    logic [1:0]       requests;
    logic [1:0]       grants;
    logic             out_valid;
    logic             out_src;
    logic [WIDTH-1:0] out_data;
    logic             err;

    dual_request_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .requests   (requests),
        .grants     (grants),
        .out_valid  (out_valid),
        .out_src    (out_src),
        .out_data   (out_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DUAL_REQUEST_QUEUE_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: two plain queues plus the expected output registers.
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    logic             m_ov;
    logic             m_src;
    logic [WIDTH-1:0] m_data;
    logic             m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_req();
        return {mq1.size() != 0, mq0.size() != 0};
    endfunction

    function automatic logic [1:0] m_rdy();
        return {mq1.size() != DEPTH, mq0.size() != DEPTH};
    endfunction

    // One clock of the reference model, evaluated from pre-edge inputs.
    task automatic model_step();
        logic [1:0] rdy;
        bit         legal;
        rdy = m_rdy();
        if (!rst) begin
            mq0.delete();
            mq1.delete();
            m_ov = 0; m_src = 0; m_data = '0; m_err = 0;
            return;
        end
        legal = (grants == 2'b01 && mq0.size() > 0) || (grants == 2'b10 && mq1.size() > 0);
        m_ov = legal;
        if (legal) begin
            m_src  = grants[1];
            m_data = grants[1] ? mq1.pop_front() : mq0.pop_front();
        end else if (ERR_EN && grants != 2'b00) begin
            m_err = 1'b1;
        end
        if (push_valid[0] && rdy[0]) mq0.push_back(push_data0);
        if (push_valid[1] && rdy[1]) mq1.push_back(push_data1);
    endtask

    task automatic model_compare();
        check("out_valid",  32'(out_valid),  32'(m_ov));
        check("out_src",    32'(out_src),    32'(m_src));
        check("out_data",   32'(out_data),   32'(m_data));
        check("requests",   32'(requests),   32'(m_req()));
        check("push_ready", 32'(push_ready), 32'(m_rdy()));
        check("err",        32'(err),        32'(m_err));
    endtask

    // Apply inputs at a falling edge and advance to the next falling edge.
    task automatic drive(input logic [1:0] pv, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] g);
        push_valid = pv; push_data0 = d0; push_data1 = d1; grants = g;
        @(negedge clk);
    endtask

    task automatic stimulus();
        rst = 1'b0;
        push_valid = 2'b00; push_data0 = '0; push_data1 = '0; grants = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("rst_requests",   32'(requests),   32'h0);
        check("rst_push_ready", 32'(push_ready), 32'h3);
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_data",   32'(out_data),   32'h0);
        check("rst_err",        32'(err),        32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single push then grant.
        drive(2'b01, 8'hA1, 8'h00, 2'b00);
        check("a1_requests", 32'(requests), 32'h1);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("a1_valid",    32'(out_valid), 32'h1);
        check("a1_src",      32'(out_src),   32'h0);
        check("a1_data",     32'(out_data),  32'hA1);
        check("a1_requests_after", 32'(requests), 32'h0);

        // Fill queue 1, overflow push ignored, drain in order.
        for (int k = 0; k < 4; k++) drive(2'b10, 8'h00, 8'(8'h10 + k), 2'b00);
        check("full_push_ready", 32'(push_ready), 32'h1);
        drive(2'b10, 8'h00, 8'h55, 2'b00);
        check("full_requests", 32'(requests), 32'h2);
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 8'h00, 8'h00, 2'b10);
            check("drain_data", 32'(out_data), 32'(8'h10 + k));
            check("drain_src",  32'(out_src),  32'h1);
        end
        check("drain_requests", 32'(requests), 32'h0);
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_hold",  32'(out_data),  32'h13);

        // Alternating back-to-back grants.
        drive(2'b11, 8'hB0, 8'hC0, 2'b00);
        drive(2'b11, 8'hB1, 8'hC1, 2'b00);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("alt0", 32'({out_valid, out_src, out_data}), 32'({1'b1, 1'b0, 8'hB0}));
        drive(2'b00, 8'h00, 8'h00, 2'b10);
        check("alt1", 32'({out_valid, out_src, out_data}), 32'({1'b1, 1'b1, 8'hC0}));
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("alt2", 32'({out_valid, out_src, out_data}), 32'({1'b1, 1'b0, 8'hB1}));
        drive(2'b00, 8'h00, 8'h00, 2'b10);
        check("alt3", 32'({out_valid, out_src, out_data}), 32'({1'b1, 1'b1, 8'hC1}));

        // Simultaneous push/pop on queue 0 across pointer wrap.
        drive(2'b01, 8'hD0, 8'h00, 2'b00);
        drive(2'b01, 8'hD1, 8'h00, 2'b00);
        for (int k = 2; k < 9; k++) begin
            drive(2'b01, 8'(8'hD0 + k), 8'h00, 2'b01);
            check("pp_data",  32'(out_data),   32'(8'hD0 + k - 2));
            check("pp_ready", 32'(push_ready), 32'h3);
        end
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("pp_tail0", 32'(out_data), 32'hD7);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("pp_tail1", 32'(out_data), 32'hD8);
        check("pp_empty", 32'(requests), 32'h0);

        // Illegal grants: both bits, then queue 1 while empty.
        drive(2'b01, 8'hE0, 8'h00, 2'b00);
        drive(2'b00, 8'h00, 8'h00, 2'b11);
        check("ill11_valid", 32'(out_valid), 32'h0);
        check("ill11_req",   32'(requests),  32'h1);
        check("ill11_err",   32'(err),       32'(ERR_EN));
        drive(2'b00, 8'h00, 8'h00, 2'b10);
        check("illempty_valid", 32'(out_valid), 32'h0);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("ill_after_data", 32'(out_data), 32'hE0);
        check("ill_err_held",   32'(err),      32'(ERR_EN));

        // Reset mid-stream with entries queued and out_valid high.
        drive(2'b01, 8'hF0, 8'h00, 2'b00);
        drive(2'b11, 8'hF1, 8'hF2, 2'b00);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_requests",   32'(requests),   32'h0);
        check("mid_rst_valid",      32'(out_valid),  32'h0);
        check("mid_rst_push_ready", 32'(push_ready), 32'h3);
        check("mid_rst_err",        32'(err),        32'h0);
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        drive(2'b01, 8'h77, 8'h00, 2'b00);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        check("post_rst_data", 32'(out_data), 32'h77);
        check("post_rst_req",  32'(requests), 32'h0);

        // Mixed traffic checked by the model alone.
        for (int k = 0; k < 60; k++) begin
            logic [1:0] g;
            g = (k % 11 == 5) ? 2'b11 : 2'($urandom_range(0, 2));
            drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), g);
        end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
    endtask

    initial begin
        m_ov = 0; m_src = 0; m_data = '0; m_err = 0;
        fork
            forever begin
                @(posedge clk);
                model_step();
                #1;
                model_compare();
            end
            stimulus();
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
